// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transfer sequencer between the TX/RX FIFOs and the SPI pins.
// Define SPI_XFER_LOOPBACK_EN to sample the driven mosi instead of the miso pin.
module spi_xfer_ctrl #(
   parameter int DWIDTH  = 8,
   parameter int CLK_DIV = 2
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              ctrl_en,
   input  logic              txfifo_empty,
   input  logic [DWIDTH-1:0] txfifo_rdata,
   output logic              txfifo_pop,
   input  logic              rxfifo_full,
   output logic [DWIDTH-1:0] rxfifo_wdata,
   output logic              rxfifo_push,
   input  logic              rx_ovf_clr,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              ss_n,
   output logic              busy,
   output logic              rx_ovf
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DWIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      STORE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DWIDTH-1:0] shreg;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              start;
   logic              div_wrap;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              last_fall;
   logic              sample_bit;

`ifdef SPI_XFER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso;
   assign sample_bit  = mosi;
`else
   assign sample_bit  = miso;
`endif

   assign start     = ctrl_en && !txfifo_empty;
   assign div_wrap  = (state == SHIFT) && (div_cnt == DIV_LAST);
   assign sclk_rise = div_wrap && !sclk;
   assign sclk_fall = div_wrap && sclk;
   assign last_fall = sclk_fall && (bit_cnt == BIT_LAST);
   assign busy      = (state != IDLE);

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      txfifo_pop   = 1'b0;
      rxfifo_push  = 1'b0;
      rxfifo_wdata = '0;
      case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD: begin
            txfifo_pop = 1'b1;
            state_nxt  = SHIFT;
         end
         SHIFT: if (last_fall) state_nxt = STORE;
         STORE: begin
            if (!rxfifo_full) begin
               rxfifo_push  = 1'b1;
               rxfifo_wdata = shreg;
            end
            state_nxt = start ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         ss_n    <= 1'b1;
      end else begin
         case (state)
            LOAD: begin
               shreg   <= txfifo_rdata;
               mosi    <= txfifo_rdata[DWIDTH-1];
               ss_n    <= 1'b0;
               bit_cnt <= '0;
               div_cnt <= '0;
               sclk    <= 1'b0;
            end
            SHIFT: begin
               div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
               if (div_wrap) sclk <= !sclk;
               // Capture on the rising edge; the shift exposes the next TX bit at the MSB.
               if (sclk_rise) shreg <= {shreg[DWIDTH-2:0], sample_bit};
               if (sclk_fall) begin
                  mosi    <= shreg[DWIDTH-1];
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            STORE: if (!start) ss_n <= 1'b1;
            default: ;
         endcase
      end
   end

   // A drop in STORE wins over a simultaneous clear so no overflow goes unreported.
   always_ff @(posedge PCLK) begin
      if (PRESET)                           rx_ovf <= 1'b0;
      else if (state == STORE && rxfifo_full) rx_ovf <= 1'b1;
      else if (rx_ovf_clr)                  rx_ovf <= 1'b0;
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl (defaults plus a CLK_DIV=1 instance).
module tb_spi_xfer_ctrl;

   logic PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   logic       PRESET = 1'b1;
   logic       ctrl_en = 1'b0;
   logic       rxfifo_full = 1'b0;
   logic       rx_ovf_clr = 1'b0;
   logic       txfifo_empty, txfifo_pop, rxfifo_push;
   logic [7:0] txfifo_rdata, rxfifo_wdata;
   logic       sclk, mosi, miso, ss_n, busy, rx_ovf;

   // TX FIFO model and per-word slave response
   logic [7:0] tx_mem   [16];
   logic [7:0] miso_mem [16];
   logic [7:0] rx_mem   [16];
   int tx_wr = 0, tx_rd = 0, rx_cnt = 0, pop_base = 0;
   int busy_cyc = 0, ss_low = 0, ss_rise = 0;
   logic [15:0] mosi_bits = '0;
   logic [7:0]  miso_sh = '0;
   logic ss_q = 1'b1, sclk_q = 1'b0;

   assign txfifo_empty = (tx_rd == tx_wr);
   assign txfifo_rdata = tx_mem[tx_rd];
   assign miso         = miso_sh[7];

   int n_tests = 0, n_fail = 0;

   spi_xfer_ctrl #(.DWIDTH(8), .CLK_DIV(2)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .ctrl_en(ctrl_en),
      .txfifo_empty(txfifo_empty), .txfifo_rdata(txfifo_rdata), .txfifo_pop(txfifo_pop),
      .rxfifo_full(rxfifo_full), .rxfifo_wdata(rxfifo_wdata), .rxfifo_push(rxfifo_push),
      .rx_ovf_clr(rx_ovf_clr), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
      .busy(busy), .rx_ovf(rx_ovf)
   );

   always @(posedge PCLK) begin
      if (txfifo_pop) tx_rd <= tx_rd + 1;
      if (rxfifo_push) begin
         rx_mem[rx_cnt] <= rxfifo_wdata;
         rx_cnt <= rx_cnt + 1;
      end
   end

   always @(negedge PCLK) begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (!ss_n) ss_low <= ss_low + 1;
      if (ss_n && !ss_q) ss_rise <= ss_rise + 1;
      ss_q <= ss_n;
      if (sclk && !sclk_q) mosi_bits <= {mosi_bits[14:0], mosi};
      sclk_q <= sclk;
      if (txfifo_pop) miso_sh <= miso_mem[tx_rd];
      else if (!sclk && sclk_q) miso_sh <= miso_sh << 1;
   end

   // Second instance: fastest divider, TX word fixed at 0xC3, miso held low
   logic       ctrl_en1 = 1'b1, empty1 = 1'b1, full1 = 1'b0, clr1 = 1'b0, miso1 = 1'b0;
   logic [7:0] rdata1 = 8'hC3;
   logic [7:0] wdata1, rx1 = '0, mosi1_bits = '0;
   logic       pop1, push1, sclk1, mosi1, ss_n1, busy1, ovf1, sclk1_q = 1'b0;
   int         busy1_cyc = 0, rx1_cnt = 0;

   spi_xfer_ctrl #(.DWIDTH(8), .CLK_DIV(1)) dut1 (
      .PCLK(PCLK), .PRESET(PRESET), .ctrl_en(ctrl_en1),
      .txfifo_empty(empty1), .txfifo_rdata(rdata1), .txfifo_pop(pop1),
      .rxfifo_full(full1), .rxfifo_wdata(wdata1), .rxfifo_push(push1),
      .rx_ovf_clr(clr1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss_n(ss_n1),
      .busy(busy1), .rx_ovf(ovf1)
   );

   always @(posedge PCLK) begin
      if (push1) begin
         rx1 <= wdata1;
         rx1_cnt <= rx1_cnt + 1;
      end
   end

   always @(negedge PCLK) begin
      if (busy1) busy1_cyc <= busy1_cyc + 1;
      if (sclk1 && !sclk1_q) mosi1_bits <= {mosi1_bits[6:0], mosi1};
      sclk1_q <= sclk1;
   end

   task automatic clear_counters();
      busy_cyc = 0; ss_low = 0; ss_rise = 0; mosi_bits = '0; rx_cnt = 0; pop_base = tx_rd;
   endtask

   task automatic push_tx(input logic [7:0] t, input logic [7:0] m);
      tx_mem[tx_wr] = t;
      miso_mem[tx_wr] = m;
      tx_wr = tx_wr + 1;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      bit seen = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge PCLK);
         if (busy) seen = 1'b1;
         else if (seen) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge PCLK);
      n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
      n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      n_tests++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ovf: got %b want 0", rx_ovf); end
      n_tests++; if (txfifo_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b want 0", txfifo_pop); end
      n_tests++; if (rxfifo_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", rxfifo_push); end
      n_tests++; if (rxfifo_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", rxfifo_wdata); end
      PRESET = 1'b0;
      @(negedge PCLK);
   endtask

   task automatic test_single_frame();
      bit ok;
      clear_counters();
      push_tx(8'hA5, 8'h3C);
      ctrl_en = 1'b1;
      wait_idle(100, ok);
      ctrl_en = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got busy=%b want frame end", busy); end
      n_tests++; if (mosi_bits[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_mosi: got %h want a5", mosi_bits[7:0]); end
      n_tests++; if (tx_rd - pop_base != 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", tx_rd - pop_base); end
      n_tests++; if (rx_cnt != 1) begin n_fail++; $display("FAIL single_pushes: got %0d want 1", rx_cnt); end
      n_tests++; if (rx_mem[0] !== 8'h3C) begin n_fail++; $display("FAIL single_rx: got %h want 3c", rx_mem[0]); end
      n_tests++; if (ss_low != 33) begin n_fail++; $display("FAIL single_ss_low: got %0d want 33", ss_low); end
      n_tests++; if (busy_cyc != 34) begin n_fail++; $display("FAIL single_busy: got %0d want 34", busy_cyc); end
      n_tests++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL single_ss_idle: got %b want 1", ss_n); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_counters();
      push_tx(8'h01, 8'h81);
      push_tx(8'hFF, 8'h7E);
      ctrl_en = 1'b1;
      wait_idle(200, ok);
      ctrl_en = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got busy=%b want frame end", busy); end
      n_tests++; if (mosi_bits !== 16'h01FF) begin n_fail++; $display("FAIL b2b_mosi: got %h want 01ff", mosi_bits); end
      n_tests++; if (tx_rd - pop_base != 2) begin n_fail++; $display("FAIL b2b_pops: got %0d want 2", tx_rd - pop_base); end
      n_tests++; if (rx_cnt != 2) begin n_fail++; $display("FAIL b2b_pushes: got %0d want 2", rx_cnt); end
      n_tests++; if (rx_mem[0] !== 8'h81) begin n_fail++; $display("FAIL b2b_rx0: got %h want 81", rx_mem[0]); end
      n_tests++; if (rx_mem[1] !== 8'h7E) begin n_fail++; $display("FAIL b2b_rx1: got %h want 7e", rx_mem[1]); end
      n_tests++; if (busy_cyc != 68) begin n_fail++; $display("FAIL b2b_busy: got %0d want 68", busy_cyc); end
      n_tests++; if (ss_low != 67) begin n_fail++; $display("FAIL b2b_ss_low: got %0d want 67", ss_low); end
      n_tests++; if (ss_rise != 1) begin n_fail++; $display("FAIL b2b_ss_rise: got %0d want 1", ss_rise); end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_counters();
      rxfifo_full = 1'b1;
      push_tx(8'h5A, 8'hFF);
      ctrl_en = 1'b1;
      wait_idle(100, ok);
      ctrl_en = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: got busy=%b want frame end", busy); end
      n_tests++; if (rx_cnt != 0) begin n_fail++; $display("FAIL ovf_no_push: got %0d want 0", rx_cnt); end
      n_tests++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", rx_ovf); end
      rx_ovf_clr = 1'b1;
      @(negedge PCLK);
      rx_ovf_clr = 1'b0;
      n_tests++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", rx_ovf); end
      // Second frame: clear pulse lands exactly on the STORE edge
      push_tx(8'hA0, 8'h0F);
      ctrl_en = 1'b1;
      repeat (34) @(negedge PCLK);
      n_tests++; if (busy !== 1'b1 || rx_ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovf_store_pre: got busy=%b ovf=%b want 1/0", busy, rx_ovf);
      end
      rx_ovf_clr = 1'b1;
      @(negedge PCLK);
      rx_ovf_clr = 1'b0;
      ctrl_en = 1'b0;
      n_tests++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", rx_ovf); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_frame_len: got busy=%b want 0", busy); end
      n_tests++; if (rx_cnt != 0) begin n_fail++; $display("FAIL ovf_no_push2: got %0d want 0", rx_cnt); end
      rxfifo_full = 1'b0;
      rx_ovf_clr = 1'b1;
      @(negedge PCLK);
      rx_ovf_clr = 1'b0;
   endtask

   task automatic test_ctrl_drop();
      bit ok;
      clear_counters();
      push_tx(8'h55, 8'hC6);
      push_tx(8'h33, 8'h3A);
      ctrl_en = 1'b1;
      repeat (15) @(negedge PCLK);
      ctrl_en = 1'b0;
      wait_idle(100, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL drop_timeout: got busy=%b want frame end", busy); end
      n_tests++; if (busy_cyc != 34) begin n_fail++; $display("FAIL drop_busy: got %0d want 34", busy_cyc); end
      n_tests++; if (mosi_bits[7:0] !== 8'h55) begin n_fail++; $display("FAIL drop_mosi: got %h want 55", mosi_bits[7:0]); end
      n_tests++; if (rx_cnt != 1 || rx_mem[0] !== 8'hC6) begin
         n_fail++; $display("FAIL drop_rx: got %0d words, %h want 1 word c6", rx_cnt, rx_mem[0]);
      end
      n_tests++; if (tx_rd - pop_base != 1) begin n_fail++; $display("FAIL drop_pops: got %0d want 1", tx_rd - pop_base); end
      n_tests++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL drop_ss_n: got %b want 1", ss_n); end
      repeat (3) @(negedge PCLK);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_stays_idle: got %b want 0", busy); end
      ctrl_en = 1'b1;
      wait_idle(100, ok);
      ctrl_en = 1'b0;
      n_tests++; if (!ok || rx_cnt != 2 || rx_mem[1] !== 8'h3A) begin
         n_fail++; $display("FAIL drop_resume: got %0d words, %h want 2 words 3a", rx_cnt, rx_mem[1]);
      end
      n_tests++; if (mosi_bits[7:0] !== 8'h33) begin n_fail++; $display("FAIL drop_resume_mosi: got %h want 33", mosi_bits[7:0]); end
   endtask

   task automatic test_preset_mid();
      clear_counters();
      push_tx(8'h96, 8'h69);
      ctrl_en = 1'b1;
      repeat (24) @(negedge PCLK);
      n_tests++; if (busy !== 1'b1 || ss_n !== 1'b0) begin
         n_fail++; $display("FAIL preset_mid_frame: got busy=%b ss_n=%b want 1/0", busy, ss_n);
      end
      PRESET = 1'b1;
      ctrl_en = 1'b0;
      @(negedge PCLK);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL preset_busy: got %b want 0", busy); end
      n_tests++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL preset_ss_n: got %b want 1", ss_n); end
      n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL preset_sclk: got %b want 0", sclk); end
      n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL preset_mosi: got %b want 0", mosi); end
      PRESET = 1'b0;
      repeat (40) @(negedge PCLK);
      n_tests++; if (rx_cnt != 0) begin n_fail++; $display("FAIL preset_no_push: got %0d want 0", rx_cnt); end
      n_tests++; if (tx_rd != tx_wr) begin n_fail++; $display("FAIL preset_consumed: got rd=%0d want %0d", tx_rd, tx_wr); end
   endtask

   task automatic test_fast_div();
      bit ok = 1'b0;
      logic [7:0] exp_rx;
`ifdef SPI_XFER_LOOPBACK_EN
      exp_rx = 8'hC3;
`else
      exp_rx = 8'h00;
`endif
      busy1_cyc = 0;
      rx1_cnt = 0;
      empty1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         if (pop1) begin ok = 1'b1; break; end
      end
      empty1 = 1'b1;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL fast_pop: got no pop want pop"); end
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge PCLK);
         if (!busy1) begin ok = 1'b1; break; end
      end
      n_tests++; if (!ok || busy1_cyc != 18) begin
         n_fail++; $display("FAIL fast_frame_len: got %0d want 18", busy1_cyc);
      end
      n_tests++; if (rx1_cnt != 1 || rx1 !== exp_rx) begin
         n_fail++; $display("FAIL fast_rx: got %0d words, %h want 1 word %h", rx1_cnt, rx1, exp_rx);
      end
      n_tests++; if (mosi1_bits !== 8'hC3) begin n_fail++; $display("FAIL fast_mosi: got %h want c3", mosi1_bits); end
      n_tests++; if (ss_n1 !== 1'b1) begin n_fail++; $display("FAIL fast_ss_n: got %b want 1", ss_n1); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_ctrl_drop();
      test_preset_mid();
      test_fast_div();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

SPI master transfer sequencer sitting between the TX/RX FIFOs and the SPI pins of the SPI peripheral. It pops words from the TX FIFO, shifts them out MSB-first in SPI mode 0 with a programmable SCLK divider, captures the returned MISO word and pushes it into the RX FIFO. Enable comes from the APB control register; busy and overflow status feed back into the APB status register.

## Interface
Parameters:
- DWIDTH, 8, word length in bits; also the TX/RX FIFO data width.
- CLK_DIV, 2, PCLK cycles per SCLK half-period; must be ≥1.

Ports:
- PCLK  in  1  system clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- ctrl_en  in  1  transfer enable from the control register.
- txfifo_empty  in  1  TX FIFO empty.
- txfifo_rdata  in  DWIDTH  TX FIFO head word; show-ahead, valid whenever !txfifo_empty.
- txfifo_pop  out  1  one-cycle pop strobe.
- rxfifo_full  in  1  RX FIFO full.
- rxfifo_wdata  out  DWIDTH  word to push.
- rxfifo_push  out  1  one-cycle push strobe.
- rx_ovf_clr  in  1  clears rx_ovf.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in; assumed synchronous to PCLK.
- ss_n  out  1  slave select, active low.
- busy  out  1  high in any state other than IDLE.
- rx_ovf  out  1  sticky RX overflow flag.

## Operation
- FSM states: IDLE, LOAD, SHIFT, STORE.
- IDLE: ss_n=1, sclk=0. If ctrl_en && !txfifo_empty, go to LOAD.
- LOAD (1 cycle): txfifo_pop=1. Shift register <= txfifo_rdata. mosi <= txfifo_rdata[DWIDTH-1]. ss_n <= 0. Bit counter <= 0. Divider <= 0. Go to SHIFT.
- SHIFT: divider counts 0..CLK_DIV-1 and wraps. Each wrap toggles sclk.
  - sclk 0→1 edge: sample miso into shift register LSB; shift register shifts left by one.
  - sclk 1→0 edge: mosi <= new shift register MSB; bit counter increments.
  - After the DWIDTH-th falling edge, go to STORE.
- STORE (1 cycle):
  - If !rxfifo_full: rxfifo_push=1, rxfifo_wdata = captured word.
  - Otherwise: no push, word is dropped, rx_ovf <= 1.
  - Next state: if ctrl_en && !txfifo_empty go to LOAD with ss_n held low (back-to-back frame); else go to IDLE with ss_n <= 1.
- ctrl_en falling mid-frame: current word completes, including STORE; the FSM then returns to IDLE. Words are never truncated.
- rx_ovf: set in STORE on overflow; cleared by rx_ovf_clr or PRESET. Set takes priority over a simultaneous clear.
- txfifo_pop and rxfifo_push are combinational decodes of LOAD and STORE; neither is asserted outside those states.

## Timing
- Reset values: state=IDLE, sclk=0, mosi=0, ss_n=1, busy=0, rx_ovf=0, txfifo_pop=0, rxfifo_push=0, rxfifo_wdata=0, counters=0.
- PRESET asserted mid-frame: on the next edge all outputs take their reset values. No push occurs and the partial word is lost.
- Cycle 0 sees the IDLE condition true; cycle 1 is LOAD; SHIFT lasts 2·CLK_DIV·DWIDTH cycles; then 1 STORE cycle.
- Frame length is 2·CLK_DIV·DWIDTH+2 cycles. For the defaults (DWIDTH=8, CLK_DIV=2) this is 34 cycles.
- The first rising sclk occurs CLK_DIV cycles after LOAD, so the first mosi bit has a full half-period of setup.
- Back-to-back frames: STORE→LOAD with no IDLE cycle; ss_n stays low continuously.
- Divider width is $clog2(CLK_DIV+1); bit counter width is $clog2(DWIDTH+1). There is no overflow beyond terminal count.

## Configuration
- SPI_XFER_LOOPBACK_EN:
  - Defined: the internal sample source is mosi instead of the miso pin. The pin is ignored and the received word equals the transmitted word.
  - Undefined: the miso pin is sampled.
  - sclk, mosi and ss_n are driven identically in both builds.

## Test plan
- Single frame, defaults: push 0xA5 to TX, miso driven with 0x3C MSB-first, ctrl_en=1 → mosi shows 1010_0101 on rising edges, exactly one pop, RX receives 0x3C, ss_n low for 33 cycles, busy falls after 34 cycles.
- Back-to-back: TX holds 0x01, 0xFF → two frames with no IDLE cycle, ss_n never rises between them, two pops and two pushes, then IDLE.
- Overflow: rxfifo_full=1 during STORE → no push, rx_ovf=1; rx_ovf_clr pulse → rx_ovf=0; set with a simultaneous clear → rx_ovf stays 1.
- ctrl_en dropped at bit 3 with 0x55 plus a second word queued → first frame completes and pushes, second word is not popped, ss_n returns high.
- PRESET asserted at bit 5 → next cycle state IDLE, ss_n=1, sclk=0, no push; the TX word remains consumed.
- With SPI_XFER_LOOPBACK_EN and CLK_DIV=1: send 0xC3 with miso held at 0 → RX receives 0xC3; frame length is 18 cycles.
